// File: rtl/iterative_alu_if.sv
// rtl/iterative_alu_if.sv - request/result bundle between the EX stage and the iterative ALU
interface iterative_alu_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [2:0]       select_bits;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;
    logic             zero;
    logic             negative;
    logic             carryOut;
    logic             overflow;

    modport master (
        output start, select_bits, A, B,
        input  out, rem, busy, done, zero, negative, carryOut, overflow
    );

    modport slave (
        input  start, select_bits, A, B,
        output out, rem, busy, done, zero, negative, carryOut, overflow
    );
endinterface

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - registered ALU with single-cycle logic/add/sub and iterative MUL/UDIV
module iterative_alu #(
    parameter int WIDTH = 64
) (
    input logic            clk,
    input logic            reset,
    iterative_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_MUL    = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;
    localparam logic [2:0] OP_UDIV   = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;   // MUL: upper product half; UDIV: partial remainder
    logic [WIDTH-1:0] lo_q;   // MUL: shifting multiplier/low product; UDIV: dividend/quotient

    logic             accept;
    logic             iter_op;
    logic             last_step;
    logic             busy_c, done_c;

    logic [WIDTH-1:0] out_q, rem_q;
    logic             zero_q, neg_q, carry_q, ovf_q;

    // Input side: an op is taken whenever the unit is not mid-iteration.
    assign accept    = bus.start && (state_q != RUN);
    assign iter_op   = (bus.select_bits == OP_MUL) ||
                       ((bus.select_bits == OP_UDIV) && (bus.B != '0));
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: IDLE and DONE both accept; RUN counts WIDTH steps then reports
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) state_d = iter_op ? RUN : DONE;
                else           state_d = IDLE;
            end
            RUN:     if (last_step) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_c = (state_q == RUN);
        done_c = (state_q == DONE);
    end

    // One shift-add multiply step: conditionally add B to the upper half, shift right
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;
    always_comb begin
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[WIDTH];
        div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo    = {lo_q[WIDTH-2:0], div_ge};
    end

    // Shared adder for ADD/SUB; SUB feeds ~B with carry-in 1
    logic             is_sub;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic             msb_cin;
    always_comb begin
        is_sub  = (bus.select_bits == OP_SUB);
        addend  = is_sub ? ~bus.B : bus.B;
        sum     = {1'b0, bus.A} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
        msb_cin = bus.A[WIDTH-1] ^ addend[WIDTH-1] ^ sum[WIDTH-1];
    end

    // Result that will be captured on the edge entering DONE
    logic [WIDTH-1:0] fin_out, fin_rem;
    logic             fin_c, fin_v;
    always_comb begin
        fin_out = '0;
        fin_rem = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        if (state_q == RUN) begin
            if (op_q == OP_UDIV) begin
                fin_out = div_lo;
                fin_rem = div_hi;
            end else begin
                fin_out = mul_lo;
                fin_v   = |mul_hi;
            end
        end else begin
            case (bus.select_bits)
                OP_PASS_B: fin_out = bus.B;
                OP_ADD, OP_SUB: begin
                    fin_out = sum[WIDTH-1:0];
                    fin_c   = sum[WIDTH];
                    fin_v   = msb_cin ^ sum[WIDTH];
                end
                OP_AND:    fin_out = bus.A & bus.B;
                OP_OR:     fin_out = bus.A | bus.B;
                OP_XOR:    fin_out = bus.A ^ bus.B;
                // Only reached with B == 0; a non-zero divisor goes to RUN instead
                OP_UDIV: begin
                    fin_out = '1;
                    fin_rem = bus.A;
                    fin_v   = 1'b1;
                end
                default: fin_out = '0;
            endcase
        end
    end

    // Operand capture, iteration registers and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            op_q    <= OP_PASS_B;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= bus.select_bits;
                b_q   <= bus.B;
                cnt_q <= '0;
                hi_q  <= '0;
                lo_q  <= bus.A;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + CW'(1);
                hi_q  <= (op_q == OP_UDIV) ? div_hi : mul_hi;
                lo_q  <= (op_q == OP_UDIV) ? div_lo : mul_lo;
            end
            if (state_d == DONE) begin
                out_q   <= fin_out;
                rem_q   <= fin_rem;
                zero_q  <= (fin_out == '0);
                neg_q   <= fin_out[WIDTH-1];
                carry_q <= fin_c;
                ovf_q   <= fin_v;
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.out      = out_q;
    assign bus.rem      = rem_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
    assign bus.carryOut = carry_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - scoreboard bench for iterative_alu at WIDTH=8 and WIDTH=64
module tb_iterative_alu;
    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_MUL    = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;
    localparam logic [2:0] OP_UDIV   = 3'b111;

    typedef struct {
        logic [63:0] out;
        logic [63:0] rem;
        logic [3:0]  flags;   // {zero, negative, carryOut, overflow}
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    exp_t q8[$];
    exp_t q64[$];

    iterative_alu_if #(.WIDTH(8))  bus8();
    iterative_alu_if #(.WIDTH(64)) bus64();

    iterative_alu #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(bus8));
    iterative_alu #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(bus64));

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [63:0] a_in, input logic [63:0] b_in,
                                   output int lat);
        exp_t         e;
        logic [63:0]  mask, a, b, o, r;
        logic [127:0] wide;
        logic         c, v;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        o = '0; r = '0; c = 1'b0; v = 1'b0; lat = 1;
        case (op)
            OP_PASS_B: o = b;
            OP_MUL: begin
                wide = {64'd0, a} * {64'd0, b};
                o    = wide[63:0] & mask;
                v    = (wide >> w) != 128'd0;
                lat  = w + 1;
            end
            OP_ADD: begin
                wide = {64'd0, a} + {64'd0, b};
                o    = wide[63:0] & mask;
                c    = wide[w];
                v    = (a[w-1] == b[w-1]) && (o[w-1] != a[w-1]);
            end
            OP_SUB: begin
                o = (a - b) & mask;
                c = (a >= b);
                v = (a[w-1] != b[w-1]) && (o[w-1] != a[w-1]);
            end
            OP_AND: o = a & b;
            OP_OR:  o = a | b;
            OP_XOR: o = a ^ b;
            default: begin
                if (b == 64'd0) begin
                    o = mask; r = a; v = 1'b1;
                end else begin
                    o = a / b; r = a % b; lat = w + 1;
                end
            end
        endcase
        e.out = o; e.rem = r; e.flags = {o == 64'd0, o[w-1], c, v}; e.due = 0;
        return e;
    endfunction

    task automatic issue8(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   lat;
        e = model(8, op, a, b, lat);
        e.due = cycle + lat;
        bus8.select_bits = op; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.start = 1'b1;
        q8.push_back(e);
        @(negedge clk);
    endtask

    task automatic issue64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   lat;
        e = model(64, op, a, b, lat);
        e.due = cycle + lat;
        bus64.select_bits = op; bus64.A = a; bus64.B = b; bus64.start = 1'b1;
        q64.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        bus8.start = 1'b0;
        bus64.start = 1'b0;
        while ((q8.size() + q64.size()) > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain pending", 64'(q8.size() + q64.size()), 64'd0);
    endtask

    // Scoreboard for the 8-bit unit: every done must match the oldest pending op
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            check("w8 done expected", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                exp_t e;
                e = q8.pop_front();
                check("w8 out", bus8.out, e.out);
                check("w8 rem", bus8.rem, e.rem);
                check("w8 flags", {bus8.zero, bus8.negative, bus8.carryOut, bus8.overflow}, e.flags);
                check("w8 done cycle", 64'(cycle), 64'(e.due));
            end
        end
    end

    // Scoreboard for the 64-bit unit
    always @(negedge clk) begin
        if (bus64.done === 1'b1) begin
            check("w64 done expected", 64'(q64.size() > 0), 64'd1);
            if (q64.size() > 0) begin
                exp_t e;
                e = q64.pop_front();
                check("w64 out", bus64.out, e.out);
                check("w64 rem", bus64.rem, e.rem);
                check("w64 flags", {bus64.zero, bus64.negative, bus64.carryOut, bus64.overflow}, e.flags);
                check("w64 done cycle", 64'(cycle), 64'(e.due));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   lat;
        int   t0;
        reset = 1'b1;
        bus8.start = 1'b0;  bus8.select_bits = '0;  bus8.A = '0;  bus8.B = '0;
        bus64.start = 1'b0; bus64.select_bits = '0; bus64.A = '0; bus64.B = '0;
        repeat (3) @(negedge clk);

        check("reset out", bus8.out, 64'd0);
        check("reset rem", bus8.rem, 64'd0);
        check("reset busy/done", {bus8.busy, bus8.done}, 64'd0);
        check("reset flags", {bus8.zero, bus8.negative, bus8.carryOut, bus8.overflow}, 64'd0);
        check("reset w64 out/busy/done", {bus64.out[3:0], bus64.busy, bus64.done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // MUL abandoned by reset during its third step; no done may follow
        bus8.select_bits = OP_MUL; bus8.A = 8'h0D; bus8.B = 8'h0B; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        check("mul busy", bus8.busy, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abandon busy", bus8.busy, 64'd0);
        check("abandon done", bus8.done, 64'd0);
        check("abandon out", bus8.out, 64'd0);
        repeat (12) @(negedge clk);

        issue8(OP_ADD, 64'd1, 64'd2);
        drain();
        issue8(OP_ADD, 64'h7F, 64'h01);
        issue8(OP_SUB, 64'h05, 64'h05);
        drain();
        issue8(OP_MUL, 64'h10, 64'h11);
        drain();
        issue8(OP_MUL, 64'd3, 64'd5);
        drain();
        issue8(OP_UDIV, 64'd100, 64'd7);
        drain();
        issue8(OP_UDIV, 64'h2A, 64'd0);
        issue8(OP_SUB, 64'h03, 64'h80);
        issue8(OP_XOR, 64'hA5, 64'h5A);
        drain();

        // start held through RUN with new operands: taken on the DONE edge
        t0 = cycle;
        issue8(OP_MUL, 64'h0D, 64'h0B);
        e = model(8, OP_AND, 64'hF0, 64'h3C, lat);
        e.due = t0 + 10;
        bus8.select_bits = OP_AND; bus8.A = 8'hF0; bus8.B = 8'h3C;
        q8.push_back(e);
        repeat (9) @(negedge clk);
        drain();

        for (int i = 0; i < 10; i++) begin
            logic [2:0] op;
            case (i % 4)
                0:       op = OP_MUL;
                1:       op = OP_UDIV;
                2:       op = OP_ADD;
                default: op = OP_SUB;
            endcase
            issue8(op, 64'($urandom_range(255)), 64'($urandom_range(255)));
            drain();
        end

        // 64-bit back-to-back single-cycle ops
        issue64(OP_XOR, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_FFFF_0000);
        issue64(OP_OR,  64'h8000_0000_0000_0001, 64'h0F0F_0000_0000_0000);
        issue64(OP_PASS_B, 64'h1234, 64'h0000_0000_0000_0000);
        drain();
        issue64(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue64(OP_SUB, 64'd1, 64'd2);
        drain();
        issue64(OP_MUL, {$urandom, $urandom}, {$urandom, $urandom});
        drain();
        issue64(OP_MUL, 64'd123456789, 64'd987654321);
        drain();
        issue64(OP_UDIV, {$urandom, $urandom}, {32'd0, $urandom});
        drain();
        issue64(OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        issue64(OP_UDIV, 64'h55, 64'd0);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
